// File: rtl/sequenciador_de_funcionalidade_pkg.sv
// Shared types and constants for the functionality sequencer.
// Includes the selection wrap helpers used in the SELECT state.
package sequenciador_de_funcionalidade_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] SEL_MIN = 3'd1;
  localparam logic [2:0] SEL_MAX = 3'd7;

  // The selection wraps within 1..7, so it never reaches 0.
  function automatic logic [2:0] sel_inc(input logic [2:0] s);
    return (s == SEL_MAX) ? SEL_MIN : s + 3'd1;
  endfunction

  function automatic logic [2:0] sel_dec(input logic [2:0] s);
    return (s == SEL_MIN) ? SEL_MAX : s - 3'd1;
  endfunction

endpackage

// File: rtl/sequenciador_de_funcionalidade_if.sv
// Button inputs and decoder-facing outputs of the functionality sequencer.
// The master side drives the buttons; the slave side is the sequencer.
interface sequenciador_de_funcionalidade_if;
  logic       btn_start;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_confirm;
  logic       btn_cancel;
  logic [2:0] F;
  logic       E;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  modport master (
    output btn_start, btn_next, btn_prev, btn_confirm, btn_cancel,
    input  F, E, busy, done, state_dbg
  );

  modport slave (
    input  btn_start, btn_next, btn_prev, btn_confirm, btn_cancel,
    output F, E, busy, done, state_dbg
  );
endinterface

// File: rtl/sequenciador_de_funcionalidade_detector_de_borda.sv
// One-bit rising-edge detector; a held level yields a single event.
// Module name is detector_de_borda, instantiated once per button.
module detector_de_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign pulse = din & ~prev_q;

endmodule

// File: rtl/sequenciador_de_funcionalidade.sv
// Sequencer for the 3-to-7 functionality decoder: choose, run for a fixed
// number of cycles, pulse done. All outputs decode from registered state.
//
// state     | meaning
// ST_IDLE   | waiting for start, decoder disabled
// ST_SELECT | user browsing functionalities, F shows selection
// ST_RUN    | decoder enabled, counting down run cycles
// ST_DONE   | one-cycle done pulse, then back to idle
module sequenciador_de_funcionalidade
  import sequenciador_de_funcionalidade_pkg::*;
#(
  parameter int RUN_CYCLES = 100,
  parameter int CNT_W      = $clog2(RUN_CYCLES) + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  sequenciador_de_funcionalidade_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RUN_CYCLES - 1);

  logic ev_start, ev_next, ev_prev, ev_confirm, ev_cancel;

  detector_de_borda u_det_start   (.clk(clk), .rst_n(rst_n), .din(bus.btn_start),   .pulse(ev_start));
  detector_de_borda u_det_next    (.clk(clk), .rst_n(rst_n), .din(bus.btn_next),    .pulse(ev_next));
  detector_de_borda u_det_prev    (.clk(clk), .rst_n(rst_n), .din(bus.btn_prev),    .pulse(ev_prev));
  detector_de_borda u_det_confirm (.clk(clk), .rst_n(rst_n), .din(bus.btn_confirm), .pulse(ev_confirm));
  detector_de_borda u_det_cancel  (.clk(clk), .rst_n(rst_n), .din(bus.btn_cancel),  .pulse(ev_cancel));

  state_t           state_q, state_d;
  logic [2:0]       sel_q,   sel_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_MIN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ev_start) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        // Higher-priority events swallow next/prev in the same cycle.
        if (ev_cancel) begin
          state_d = ST_IDLE;
        end else if (ev_confirm) begin
          state_d = ST_RUN;
          cnt_d   = CNT_LOAD;
        end else if (ev_start) begin
          sel_d = sel_q;
        end else if (ev_next && !ev_prev) begin
          sel_d = sel_inc(sel_q);
        end else if (ev_prev && !ev_next) begin
          sel_d = sel_dec(sel_q);
        end
      end
      ST_RUN: begin
        if (ev_cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.F         = (state_q == ST_SELECT || state_q == ST_RUN) ? sel_q : 3'd0;
  assign bus.E         = (state_q == ST_RUN);
  assign bus.busy      = (state_q == ST_SELECT || state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sequenciador_de_funcionalidade.sv
// Directed bench for the functionality sequencer with RUN_CYCLES=4.
module tb_sequenciador_de_funcionalidade;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  sequenciador_de_funcionalidade_if bus ();

  sequenciador_de_funcionalidade #(.RUN_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Button codes: 0 start, 1 next, 2 prev, 3 confirm, 4 cancel
  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.btn_start   = v;
      1: bus.btn_next    = v;
      2: bus.btn_prev    = v;
      3: bus.btn_confirm = v;
      default: bus.btn_cancel = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick();
    set_btn(b, 1'b0);
    tick();
  endtask

  initial begin
    logic [2:0] next_exp [8];
    logic [2:0] prev_exp [3];
    next_exp = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
    prev_exp = '{3'd1, 3'd7, 3'd6};
    n_pass  = 0;
    n_total = 0;
    rst_n = 1'b0;
    bus.btn_start = 0; bus.btn_next = 0; bus.btn_prev = 0;
    bus.btn_confirm = 0; bus.btn_cancel = 0;
    #12;
    chk("rst_F", 8'(bus.F), 8'd0);
    chk("rst_E", 8'(bus.E), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_state", 8'(bus.state_dbg), 8'd0);
    #10 rst_n = 1'b1;
    tick();

    press(0);
    chk("start_state", 8'(bus.state_dbg), 8'd1);
    chk("start_F", 8'(bus.F), 8'd1);
    chk("start_busy", 8'(bus.busy), 8'd1);

    for (int i = 0; i < 8; i++) begin
      press(1);
      chk("next_F", 8'(bus.F), 8'(next_exp[i]));
      chk("next_E", 8'(bus.E), 8'd0);
    end
    for (int i = 0; i < 3; i++) begin
      press(2);
      chk("prev_F", 8'(bus.F), 8'(prev_exp[i]));
    end
    for (int i = 0; i < 3; i++) press(2);
    chk("sel3_F", 8'(bus.F), 8'd3);

    // Confirm: E high for exactly four cycles
    bus.btn_confirm = 1'b1;
    tick();
    bus.btn_confirm = 1'b0;
    chk("run_state", 8'(bus.state_dbg), 8'd2);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("run_E", 8'(bus.E), 8'd1);
      chk("run_F", 8'(bus.F), 8'd3);
      chk("run_done", 8'(bus.done), 8'd0);
    end
    tick();
    chk("done_pulse", 8'(bus.done), 8'd1);
    chk("done_F", 8'(bus.F), 8'd0);
    chk("done_E", 8'(bus.E), 8'd0);
    chk("done_busy", 8'(bus.busy), 8'd0);
    tick();
    chk("after_done", 8'(bus.done), 8'd0);
    chk("after_state", 8'(bus.state_dbg), 8'd0);
    chk("after_busy", 8'(bus.busy), 8'd0);

    press(0);
    chk("restart_F", 8'(bus.F), 8'd3);

    bus.btn_next = 1'b1;
    repeat (10) tick();
    bus.btn_next = 1'b0;
    tick();
    chk("held_next_F", 8'(bus.F), 8'd4);

    bus.btn_next = 1'b1; bus.btn_prev = 1'b1;
    tick();
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
    tick();
    chk("next_prev_F", 8'(bus.F), 8'd4);

    // Cancel during cycle 2 of the run
    bus.btn_confirm = 1'b1;
    tick();
    bus.btn_confirm = 1'b0;
    tick();
    chk("pre_cancel_E", 8'(bus.E), 8'd1);
    bus.btn_cancel = 1'b1;
    tick();
    bus.btn_cancel = 1'b0;
    chk("cancel_E", 8'(bus.E), 8'd0);
    chk("cancel_F", 8'(bus.F), 8'd0);
    chk("cancel_state", 8'(bus.state_dbg), 8'd0);
    for (int i = 0; i < 6; i++) begin
      chk("cancel_no_done", 8'(bus.done), 8'd0);
      tick();
    end

    press(0);
    bus.btn_confirm = 1'b1; bus.btn_cancel = 1'b1;
    tick();
    bus.btn_confirm = 1'b0; bus.btn_cancel = 1'b0;
    chk("conf_cancel_state", 8'(bus.state_dbg), 8'd0);
    chk("conf_cancel_E", 8'(bus.E), 8'd0);
    tick();

    press(0);
    chk("sel4_F", 8'(bus.F), 8'd4);
    for (int i = 0; i < 3; i++) press(1);
    chk("sel7_F", 8'(bus.F), 8'd7);
    bus.btn_confirm = 1'b1; bus.btn_next = 1'b1;
    tick();
    bus.btn_confirm = 1'b0; bus.btn_next = 1'b0;
    chk("conf_next_state", 8'(bus.state_dbg), 8'd2);
    chk("conf_next_F", 8'(bus.F), 8'd7);
    chk("conf_next_E", 8'(bus.E), 8'd1);
    tick();

    // Asynchronous reset between edges, mid-run
    #2 rst_n = 1'b0;
    #1;
    chk("async_E", 8'(bus.E), 8'd0);
    chk("async_F", 8'(bus.F), 8'd0);
    chk("async_busy", 8'(bus.busy), 8'd0);
    chk("async_state", 8'(bus.state_dbg), 8'd0);
    #14 rst_n = 1'b1;
    tick();
    press(0);
    chk("post_rst_state", 8'(bus.state_dbg), 8'd1);
    chk("post_rst_F", 8'(bus.F), 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
